fifo_wr_arbiter: RTL

Round-robin write-port arbiter sharing one asynchronous FIFO write port among NUM_REQ producers in the write clock domain. It grants one requester at a time for a bounded burst and gates every write against the FIFO's full flag. It drives the FIFO's data_in and wr_en directly, so the FIFO never sees a write while full.

---
 rtl/fifo_ctrl_pkg.sv | 19 +
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and width helpers for the FIFO-side schedulers.
package fifo_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } arb_state_e;

  // Index width that never collapses to zero, so one-entry vectors still get a usable index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NumReqDefault   = 4;
  localparam int unsigned MaxBurstDefault = 4;
  localparam int unsigned GrantWDefault   = $clog2(NumReqDefault);
  localparam int unsigned BeatWDefault    = idx_width(MaxBurstDefault);

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set bit of req searching upward from last+1, with wrap-around.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last,
  output logic               found,
  output logic [IdxW-1:0]    index
);

  // Scan from farthest to nearest candidate so the nearest valid one is the final assignment.
  always_comb begin
    int unsigned j;
    j     = 0;
    found = 1'b0;
    index = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (32'(last) + 32'(i)) % NUM_REQ;
      if (req[j[IdxW-1:0]]) begin
        found = 1'b1;
        index = j[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned data_width = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned GrantW    = $clog2(NUM_REQ),
  localparam int unsigned BeatW     = idx_width(MAX_BURST)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [data_width-1:0]         data_in,
  output logic [GrantW-1:0]             grant_id,
  output logic                          busy
);

  arb_state_e        state_q;
  logic [GrantW-1:0] grant_q;
  logic [GrantW-1:0] last_grant_q;
  logic [BeatW-1:0]  beat_cnt_q;

  logic                  cur_valid;
  logic [data_width-1:0] cur_data;
  logic                  accept;
  logic                  last_beat;
  logic                  release_grant;
  logic                  pick_found;
  logic [GrantW-1:0]     pick_index;

  // While granted, last_grant equals the owner, so one picker serves both IDLE and release.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (GrantW)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (last_grant_q),
    .found (pick_found),
    .index (pick_index)
  );

  // Select the owner's valid and data slice.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GrantW'(i)) begin
        cur_valid = req_valid[i];
        cur_data  = req_data[i*data_width +: data_width];
      end
    end
  end

  // Write-port outputs, gated combinationally by full so the FIFO never sees a write while full.
  always_comb begin
    busy          = (state_q == GRANT);
    accept        = busy & cur_valid & ~full;
    wr_en         = accept;
    data_in       = busy ? cur_data : '0;
    last_beat     = (beat_cnt_q == BeatW'(MAX_BURST - 1));
    release_grant = busy & (~cur_valid | (accept & last_beat));
    req_ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept & (grant_q == GrantW'(i));
    end
  end

  assign grant_id = grant_q;

  // Grant FSM: take a winner from IDLE, count beats, re-arbitrate on release with no bubble.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GrantW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q      <= GRANT;
            grant_q      <= pick_index;
            last_grant_q <= pick_index;
            beat_cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (release_grant) begin
            beat_cnt_q <= '0;
            if (pick_found) begin
              grant_q      <= pick_index;
              last_grant_q <= pick_index;
            end else begin
              state_q <= IDLE;
            end
          end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + BeatW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
